// File: rtl/fetch_pkg.sv
// Shared types and width defaults for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned FETCH_ADDR_W = 32;
    localparam int unsigned FETCH_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_buf.sv
// One-entry output buffer between fetch and decode: instruction, PC, PC+4 and a valid bit.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = FETCH_ADDR_W,
    parameter int unsigned DATA_W = FETCH_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic              pop,
    input  logic [DATA_W-1:0] load_instr,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic [ADDR_W-1:0] load_pc_add4,
    output logic              valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_add4
);

    // Clear (redirect) beats load; load and pop never coincide since loads only land in an empty buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

    // Payload only moves on load so it stays stable while decode stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr   <= '0;
            pc      <= '0;
            pc_add4 <= '0;
        end else if (load && !clear) begin
            instr   <= load_instr;
            pc      <= load_pc;
            pc_add4 <= load_pc_add4;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, one-entry decode buffer, redirect via flush.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = FETCH_ADDR_W,
    parameter int unsigned DATA_W = FETCH_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [ADDR_W-1:0] pc_add4_in,
    output logic              pc_advance,
    input  logic              flush,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [DATA_W-1:0] id_instr,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_pc_add4
);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [ADDR_W-1:0] req_pc;
    logic [ADDR_W-1:0] req_pc_add4;
    logic              capture;
    logic              load;
    logic              pop;
    logic              buf_valid;

    assign imem_req_addr = pc_in;
    assign pop           = buf_valid && id_ready;
    assign id_valid      = buf_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake strobes; flush suppresses the buffer load and pc_advance.
    always_comb begin
        state_nxt      = state;
        imem_req_valid = 1'b0;
        capture        = 1'b0;
        load           = 1'b0;
        pc_advance     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!flush) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                imem_req_valid = !buf_valid;
                if (!buf_valid && imem_req_ready) begin
                    capture   = 1'b1;
                    state_nxt = flush ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    state_nxt = REQ;
                    if (!flush) begin
                        load       = 1'b1;
                        pc_advance = 1'b1;
                    end
                end else if (flush) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_rsp_valid) begin
                    state_nxt = REQ;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // PC pair of the outstanding request, tagged onto the instruction when it returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_pc      <= '0;
            req_pc_add4 <= '0;
        end else if (capture) begin
            req_pc      <= pc_in;
            req_pc_add4 <= pc_add4_in;
        end
    end

    fetch_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .clear        (flush),
        .pop          (pop),
        .load_instr   (imem_rsp_data),
        .load_pc      (req_pc),
        .load_pc_add4 (req_pc_add4),
        .valid        (buf_valid),
        .instr        (id_instr),
        .pc           (id_pc),
        .pc_add4      (id_pc_add4)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus, expected requests/instructions queued, monitor compares.
module tb_fetch_unit;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_add4;
    } id_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic [31:0] pc_add4_in;
    logic        pc_advance;
    logic        flush;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_add4;

    int          tests = 0;
    int          fails = 0;
    int          pa_count = 0;
    int          mem_lat = 1;
    logic [31:0] exp_req[$];
    id_t         exp_id[$];

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .pc_add4_in     (pc_add4_in),
        .pc_advance     (pc_advance),
        .flush          (flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_add4     (id_pc_add4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] addr);
        if (addr == 32'd100) return 32'h2008_0005;
        return {addr[15:0], 16'hC0DE};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Instruction memory: answers each accepted request after mem_lat cycles with a one-cycle pulse.
    initial begin
        logic [31:0] maddr;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst && imem_req_valid && imem_req_ready) begin
                maddr = imem_req_addr;
                @(posedge clk);
                repeat (mem_lat - 1) @(posedge clk);
                #1;
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_data(maddr);
                @(posedge clk);
                #1;
                imem_rsp_valid = 1'b0;
            end
        end
    end

    // Monitor: compares every request handshake and decode consumption against the queues.
    initial begin
        logic [31:0] ea;
        id_t         ei;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (pc_advance) pa_count++;
                if (imem_req_valid && imem_req_ready) begin
                    if (exp_req.size() == 0) begin
                        check("unexpected_req", imem_req_addr, 32'hFFFF_FFFF);
                    end else begin
                        ea = exp_req.pop_front();
                        check("req_addr", imem_req_addr, ea);
                    end
                end
                if (id_valid && id_ready) begin
                    if (exp_id.size() == 0) begin
                        check("unexpected_id", id_instr, 32'hFFFF_FFFF);
                    end else begin
                        ei = exp_id.pop_front();
                        check("id_instr", id_instr, ei.instr);
                        check("id_pc", id_pc, ei.pc);
                        check("id_pc_add4", id_pc_add4, ei.pc_add4);
                    end
                end
            end
        end
    end

    initial begin
        rst            = 1'b1;
        pc_in          = 32'd100;
        pc_add4_in     = 32'd104;
        flush          = 1'b0;
        imem_req_ready = 1'b0;
        id_ready       = 1'b0;
        tick(2);
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_pc_advance", 32'(pc_advance), 32'd0);
        check("rst_id_instr", id_instr, 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_id_pc_add4", id_pc_add4, 32'd0);
        rst = 1'b0;

        // Memory not ready: request held at PC 100.
        tick(1);
        #1;
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, 32'd100);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            #1;
            check("stall_req_valid", 32'(imem_req_valid), 32'd1);
            check("stall_req_addr", imem_req_addr, 32'd100);
        end
        check("stall_no_advance", 32'(pa_count), 32'd0);
        exp_req.push_back(32'd100);
        imem_req_ready = 1'b1;

        // 1-cycle memory: pc_advance in the response cycle, buffer valid one cycle later.
        tick(1);
        #1;
        check("rsp_pc_advance", 32'(pc_advance), 32'd1);
        pc_in      = 32'd104;
        pc_add4_in = 32'd108;
        tick(1);
        #1;
        check("a_id_valid", 32'(id_valid), 32'd1);
        check("a_id_instr", id_instr, 32'h2008_0005);
        check("a_id_pc", id_pc, 32'd100);
        check("a_id_pc_add4", id_pc_add4, 32'd104);
        check("a_pc_advance_low", 32'(pc_advance), 32'd0);

        // Decode stalled: no new request, payload stable.
        for (int i = 0; i < 5; i++) begin
            tick(1);
            #1;
            check("hold_id_valid", 32'(id_valid), 32'd1);
            check("hold_id_instr", id_instr, 32'h2008_0005);
            check("hold_id_pc", id_pc, 32'd100);
            check("hold_no_req", 32'(imem_req_valid), 32'd0);
        end
        check("one_advance", 32'(pa_count), 32'd1);
        exp_id.push_back('{32'h2008_0005, 32'd100, 32'd104});
        exp_req.push_back(32'd104);
        id_ready = 1'b1;
        tick(1);
        #1;
        check("b_req_valid", 32'(imem_req_valid), 32'd1);
        check("b_req_addr", imem_req_addr, 32'd104);
        exp_id.push_back('{32'h0068_C0DE, 32'd104, 32'd108});
        tick(1);
        pc_in      = 32'd108;
        pc_add4_in = 32'd112;
        tick(1);

        // Flush one cycle after the handshake with a 3-cycle memory.
        exp_req.push_back(32'd108);
        mem_lat = 3;
        tick(1);
        #1;
        check("c_req_addr", imem_req_addr, 32'd108);
        tick(1);
        flush      = 1'b1;
        pc_in      = 32'd200;
        pc_add4_in = 32'd204;
        exp_req.push_back(32'd200);
        #1;
        check("flush_no_req", 32'(imem_req_valid), 32'd0);
        tick(1);
        flush = 1'b0;
        #1;
        check("drain_id_valid", 32'(id_valid), 32'd0);
        check("drain_no_req", 32'(imem_req_valid), 32'd0);
        tick(1);
        #1;
        check("drain_rsp_seen", 32'(imem_rsp_valid), 32'd1);
        check("drain_no_advance", 32'(pc_advance), 32'd0);
        check("drain_still_no_req", 32'(imem_req_valid), 32'd0);
        tick(1);
        #1;
        check("redirect_req_valid", 32'(imem_req_valid), 32'd1);
        check("redirect_req_addr", imem_req_addr, 32'd200);
        check("redirect_id_valid", 32'(id_valid), 32'd0);
        check("two_advances", 32'(pa_count), 32'd2);
        mem_lat = 1;

        // Flush coinciding with the response: dropped, straight back to REQ.
        tick(1);
        flush      = 1'b1;
        pc_in      = 32'd300;
        pc_add4_in = 32'd304;
        exp_req.push_back(32'd300);
        #1;
        check("flush_rsp_seen", 32'(imem_rsp_valid), 32'd1);
        check("flush_rsp_no_advance", 32'(pc_advance), 32'd0);
        tick(1);
        flush = 1'b0;
        #1;
        check("flush_rsp_req_valid", 32'(imem_req_valid), 32'd1);
        check("flush_rsp_req_addr", imem_req_addr, 32'd300);
        check("flush_rsp_id_valid", 32'(id_valid), 32'd0);
        mem_lat = 3;

        // Reset while waiting on a 3-cycle response; the stale response must be ignored.
        tick(1);
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        #1;
        check("midrst_req_valid", 32'(imem_req_valid), 32'd0);
        check("midrst_id_valid", 32'(id_valid), 32'd0);
        check("midrst_pc_advance", 32'(pc_advance), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(1);
        #1;
        check("stale_rsp_seen", 32'(imem_rsp_valid), 32'd1);
        check("stale_no_advance", 32'(pc_advance), 32'd0);
        tick(1);
        #1;
        check("stale_id_valid", 32'(id_valid), 32'd0);
        check("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
        check("post_rst_req_addr", imem_req_addr, 32'd300);
        check("still_two_advances", 32'(pa_count), 32'd2);

        // Normal fetch after reset recovery.
        exp_req.push_back(32'd300);
        exp_id.push_back('{32'h012C_C0DE, 32'd300, 32'd304});
        mem_lat        = 1;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 20 && exp_id.size() != 0; i++) begin
            tick(1);
        end
        check("final_id_drained", 32'(exp_id.size()), 32'd0);
        check("final_req_drained", 32'(exp_req.size()), 32'd0);
        check("three_advances", 32'(pa_count), 32'd3);
        imem_req_ready = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
